// File: rtl/vs_residual_updater.sv
// In-place residual update r[i] -= coefficient * phi[column*ROWS + i], one row per cycle,
// with a saturating sum-of-squares of the updated residual.
module vs_residual_updater #(
    parameter int ROWS       = 4,
    parameter int COLUMNS    = 8,
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [7:0]            column,
    input  logic [DATA_WIDTH-1:0] coefficient,
    output logic [15:0]           phi_read_addr,
    input  logic [DATA_WIDTH-1:0] phi_read_data,
    output logic [7:0]            res_read_addr,
    input  logic [DATA_WIDTH-1:0] res_read_data,
    output logic                  res_write_enable,
    output logic [7:0]            res_write_addr,
    output logic [DATA_WIDTH-1:0] res_write_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] residual_energy
);

    localparam int KW = $clog2(ROWS + 1);
    localparam int DW = DATA_WIDTH;
    localparam logic [KW-1:0] ROWS_K  = KW'(ROWS);
    localparam logic [8:0]    COLS_9  = 9'(COLUMNS);
    localparam logic [DW-1:0] E_MAX   = {1'b0, {(DW-1){1'b1}}};

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic [7:0]           col_q, col_d;
    logic signed [DW-1:0] coef_q, coef_d;
    logic                 wr_valid_q, wr_valid_d;
    logic [7:0]           wr_addr_q, wr_addr_d;
    logic [DW-1:0]        energy_q, energy_d;
    logic                 error_q, error_d;

    logic                   issue;
    logic                   col_legal;
    logic signed [2*DW-1:0] prod_full;
    logic [DW-1:0]          prod_trunc;
    logic signed [DW-1:0]   new_r;
    logic signed [2*DW-1:0] sq_full;
    logic signed [2*DW-1:0] sq_shift;
    logic [2*DW:0]          sum;
    logic [DW-1:0]          energy_sat;

    assign issue     = (state_q == S_RUN) && (k_q < ROWS_K);
    assign col_legal = {1'b0, column} < COLS_9;

    // Read data arrives one cycle after issue, so the write of row k overlaps the read of row k+1.
    assign prod_full  = coef_q * $signed(phi_read_data);
    assign prod_trunc = DW'(prod_full >>> FRAC_BITS);
    assign new_r      = res_read_data - prod_trunc;
    assign sq_full    = new_r * new_r;
    assign sq_shift   = sq_full >>> FRAC_BITS;
    assign sum        = {1'b0, sq_shift} + {{(DW+1){1'b0}}, energy_q};
    assign energy_sat = (sum > {{(DW+1){1'b0}}, E_MAX}) ? E_MAX : sum[DW-1:0];

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        col_d      = col_q;
        coef_d     = coef_q;
        energy_d   = energy_q;
        error_d    = 1'b0;
        wr_valid_d = issue;
        wr_addr_d  = 8'(k_q);

        if (wr_valid_q) begin
            energy_d = energy_sat;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (col_legal) begin
                        col_d    = column;
                        coef_d   = coefficient;
                        k_d      = '0;
                        energy_d = '0;
                        state_d  = S_RUN;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (issue) begin
                    k_d = k_q + KW'(1);
                end
                if (k_q == ROWS_K) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            col_q      <= '0;
            coef_q     <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            energy_q   <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            col_q      <= col_d;
            coef_q     <= coef_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            energy_q   <= energy_d;
            error_q    <= error_d;
        end
    end

    assign phi_read_addr    = issue ? (16'(col_q) * 16'(ROWS) + 16'(k_q)) : '0;
    assign res_read_addr    = issue ? 8'(k_q) : '0;
    assign res_write_enable = wr_valid_q;
    assign res_write_addr   = wr_valid_q ? wr_addr_q : '0;
    assign res_write_data   = wr_valid_q ? new_r : '0;
    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_FINISH);
    assign error            = error_q;
    assign residual_energy  = energy_q;

endmodule

// File: tb/tb_vs_residual_updater.sv
// Scoreboard bench for vs_residual_updater: a reference model queues expected writes,
// done/energy and error events; a negedge monitor pops and compares them.
module tb_vs_residual_updater;

    localparam int ROWS = 4;
    localparam int COLS = 8;
    localparam int DW   = 32;
    localparam int FRAC = 0;
    localparam int PAW  = $clog2(COLS * ROWS);
    localparam int RAW  = $clog2(ROWS);

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    column = '0;
    logic [DW-1:0] coefficient = '0;
    logic [15:0]   phi_read_addr;
    logic [DW-1:0] phi_read_data = '0;
    logic [7:0]    res_read_addr;
    logic [DW-1:0] res_read_data = '0;
    logic          res_write_enable;
    logic [7:0]    res_write_addr;
    logic [DW-1:0] res_write_data;
    logic          busy, done, error;
    logic [DW-1:0] residual_energy;

    vs_residual_updater #(
        .ROWS(ROWS), .COLUMNS(COLS), .DATA_WIDTH(DW), .FRAC_BITS(FRAC)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .column(column),
        .coefficient(coefficient), .phi_read_addr(phi_read_addr),
        .phi_read_data(phi_read_data), .res_read_addr(res_read_addr),
        .res_read_data(res_read_data), .res_write_enable(res_write_enable),
        .res_write_addr(res_write_addr), .res_write_data(res_write_data),
        .busy(busy), .done(done), .error(error), .residual_energy(residual_energy)
    );

    always #5 clock = ~clock;

    logic [DW-1:0] phi_mem [COLS*ROWS];
    logic [DW-1:0] res_mem [ROWS];
    logic [DW-1:0] exp_res [ROWS];

    // Synchronous-read RAMs with one cycle of latency.
    always @(posedge clock) begin
        phi_read_data <= phi_mem[phi_read_addr[PAW-1:0]];
        res_read_data <= res_mem[res_read_addr[RAW-1:0]];
        if (res_write_enable) res_mem[res_write_addr[RAW-1:0]] <= res_write_data;
    end

    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct { int cyc; logic [7:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct { int cyc; logic [DW-1:0] energy; } dn_t;
    wr_t wq[$];
    dn_t dq[$];
    int  eq[$];

    int n_vec = 0;
    int n_mis = 0;
    logic [DW-1:0] last_energy = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the residual array.
    task automatic run_model(input int col, input logic [DW-1:0] coef, input int c0,
                             input int nrows, input bit with_done);
        longint acc, p, sq;
        logic [DW-1:0] nr;
        acc = 0;
        for (int i = 0; i < nrows; i++) begin
            p  = longint'($signed(coef)) * longint'($signed(phi_mem[col*ROWS+i]));
            p  = p >>> FRAC;
            nr = exp_res[i] - p[DW-1:0];
            sq = longint'($signed(nr)) * longint'($signed(nr));
            sq = sq >>> FRAC;
            acc = acc + sq;
            if (acc > 64'sh7FFF_FFFF) acc = 64'sh7FFF_FFFF;
            exp_res[i] = nr;
            wq.push_back('{c0 + i + 1, 8'(i), nr});
        end
        if (with_done) begin
            dq.push_back('{c0 + ROWS + 1, acc[DW-1:0]});
            last_energy = acc[DW-1:0];
        end
    endtask

    always @(negedge clock) begin
        wr_t w;
        dn_t d;
        int  e;
        if (res_write_enable) begin
            chk("wr_expected", 64'(wq.size() != 0), 1);
            if (wq.size() != 0) begin
                w = wq.pop_front();
                chk("wr_cycle", 64'(cyc), 64'(w.cyc));
                chk("wr_addr", 64'(res_write_addr), 64'(w.addr));
                chk("wr_data", 64'(res_write_data), 64'(w.data));
            end
        end
        if (done) begin
            chk("done_expected", 64'(dq.size() != 0), 1);
            chk("busy_at_done", 64'(busy), 1);
            if (dq.size() != 0) begin
                d = dq.pop_front();
                chk("done_cycle", 64'(cyc), 64'(d.cyc));
                chk("energy", 64'(residual_energy), 64'(d.energy));
            end
        end
        if (error) begin
            chk("err_expected", 64'(eq.size() != 0), 1);
            chk("busy_at_err", 64'(busy), 0);
            if (eq.size() != 0) begin
                e = eq.pop_front();
                chk("err_cycle", 64'(cyc), 64'(e));
            end
        end
    end

    task automatic set_res(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] c, input logic [DW-1:0] d);
        res_mem[0] <= a; res_mem[1] <= b; res_mem[2] <= c; res_mem[3] <= d;
        exp_res[0] = a;  exp_res[1] = b;  exp_res[2] = c;  exp_res[3] = d;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_busy"}, 64'(busy), 0);
        chk({nm, "_done"}, 64'(done), 0);
        chk({nm, "_we"}, 64'(res_write_enable), 0);
        chk({nm, "_phi_addr"}, 64'(phi_read_addr), 0);
        chk({nm, "_res_addr"}, 64'(res_read_addr), 0);
        chk({nm, "_wr_addr"}, 64'(res_write_addr), 0);
        chk({nm, "_energy_hold"}, 64'(residual_energy), 64'(last_energy));
    endtask

    task automatic do_pass(input int col, input logic [DW-1:0] coef, input bit poke, input bit b2b);
        int c0;
        bit legal;
        @(negedge clock);
        c0 = cyc + 1;
        legal = (col < COLS);
        if (legal) run_model(col, coef, c0, ROWS, 1'b1);
        else eq.push_back(c0);
        start = 1'b1; column = 8'(col); coefficient = coef;
        @(negedge clock);
        start = 1'b0; column = 8'($urandom); coefficient = $urandom;
        #1;
        chk("busy_after_start", 64'(busy), 64'(legal));
        if (!legal) begin
            chk("err_pending", 64'(eq.size()), 0);
            @(negedge clock);
            #1;
            chk_idle("after_err");
            return;
        end
        if (poke) begin
            @(negedge clock);
            start = 1'b1; column = 8'((col + 1) % COLS); coefficient = coef + 7;
            @(negedge clock);
            start = 1'b0;
        end
        while (cyc < c0 + ROWS + 1) @(negedge clock);
        #1;
        chk("wr_pending", 64'(wq.size()), 0);
        chk("done_pending", 64'(dq.size()), 0);
        for (int i = 0; i < ROWS; i++) chk("residual_row", 64'(res_mem[i]), 64'(exp_res[i]));
        if (!b2b) begin
            @(negedge clock);
            #1;
            chk_idle("after_pass");
        end
    endtask

    task automatic reset_mid(input int col, input logic [DW-1:0] coef);
        int c0;
        @(negedge clock);
        c0 = cyc + 1;
        run_model(col, coef, c0, 2, 1'b0);
        start = 1'b1; column = 8'(col); coefficient = coef;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        #1;
        last_energy = '0;
        chk("rst_error", 64'(error), 0);
        chk("rst_wr_pending", 64'(wq.size()), 0);
        chk_idle("rst_mid");
        reset_n = 1'b1;
        for (int i = 0; i < ROWS; i++) chk("rst_row", 64'(res_mem[i]), 64'(exp_res[i]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] exp43 [ROWS];
        logic [DW-1:0] exp44 [ROWS];
        int col;
        logic [DW-1:0] coef;
        exp43 = '{32'd0, -32'sd1, -32'sd1, 32'd2};
        exp44 = '{-32'sd3, -32'sd4, 32'd0, 32'd3};
        for (int j = 0; j < COLS*ROWS; j++) phi_mem[j] = $urandom;
        set_res('0, '0, '0, '0);

        repeat (3) @(negedge clock);
        #1;
        chk("reset_error", 64'(error), 0);
        chk_idle("reset");
        reset_n = 1'b1;

        for (int i = 0; i < ROWS; i++) phi_mem[i] = 32'd1;
        phi_mem[4] = 32'd1; phi_mem[5] = 32'd1; phi_mem[6] = -32'sd1; phi_mem[7] = -32'sd1;
        set_res(-32'sd1, -32'sd2, -32'sd2, 32'd1);
        do_pass(0, -32'sd1, 1'b0, 1'b0);
        for (int i = 0; i < ROWS; i++) chk("ex43_row", 64'(res_mem[i]), 64'(exp43[i]));
        chk("ex43_energy", 64'(residual_energy), 64'd6);

        set_res(-32'sd1, -32'sd2, -32'sd2, 32'd1);
        do_pass(1, 32'sd2, 1'b0, 1'b0);
        for (int i = 0; i < ROWS; i++) chk("ex44_row", 64'(res_mem[i]), 64'(exp44[i]));
        chk("ex44_energy", 64'(residual_energy), 64'd34);

        do_pass(8, 32'sd5, 1'b0, 1'b0);

        set_res($urandom_range(0, 99), $urandom_range(0, 99), $urandom, $urandom);
        do_pass(3, 32'(int'($urandom_range(0, 20)) - 10), 1'b1, 1'b0);

        set_res(32'd11, -32'sd7, 32'd3, 32'd100);
        reset_mid(2, 32'sd3);
        do_pass(2, -32'sd4, 1'b0, 1'b0);

        phi_mem[16] = -32'sd1;
        set_res(32'h7FFF_FFFF, 32'd1, 32'd2, 32'd3);
        do_pass(4, 32'sd1, 1'b0, 1'b0);
        chk("wrap_row0", 64'(res_mem[0]), 64'h8000_0000);
        chk("energy_sat", 64'(residual_energy), 64'h7FFF_FFFF);

        do_pass(5, '0, 1'b0, 1'b0);

        do_pass(6, 32'sd9, 1'b0, 1'b1);
        do_pass(7, -32'sd3, 1'b0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) == 0)
                for (int j = 0; j < COLS*ROWS; j++)
                    phi_mem[j] = ($urandom_range(0, 1) != 0) ? $urandom : 32'(int'($urandom_range(0, 16)) - 8);
            if ($urandom_range(0, 2) == 0)
                set_res($urandom, 32'(int'($urandom_range(0, 200)) - 100), $urandom, 32'($urandom_range(0, 50)));
            col  = int'($urandom_range(0, COLS + 1));
            coef = ($urandom_range(0, 2) == 0) ? $urandom : 32'(int'($urandom_range(0, 40)) - 20);
            do_pass(col, coef, 1'($urandom_range(0, 1)), (n != 23) && ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clock);
        #1;
        chk("final_wq_empty", 64'(wq.size()), 0);
        chk("final_dq_empty", 64'(dq.size()), 0);
        chk("final_eq_empty", 64'(eq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/vs_residual_updater.md
VS_RESIDUAL_UPDATER -- requirements
Module: vs_residual_updater

Interface
REQ-001 Parameter ROWS, default 4: residual length and rows per sensing-matrix column.
REQ-002 Parameter COLUMNS, default 8: number of sensing-matrix columns.
REQ-003 Parameter DATA_WIDTH, default FP_DATA_BUS_WIDTH (32): signed two's-complement data word width.
REQ-004 Parameter FRAC_BITS, default 0: fractional bits of the fixed-point format.
REQ-005 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-006 Port reset_n, input, 1: reset, synchronous and active-low.
REQ-007 Port start, input, 1: request one update pass; sampled only in IDLE.
REQ-008 Port column, input, 8: sensing-matrix column index, sampled with start.
REQ-009 Port coefficient, input, DATA_WIDTH: signed coefficient, sampled with start.
REQ-010 Port phi_read_addr, output, 16: sensing-matrix RAM read address (column-major).
REQ-011 Port phi_read_data, input, DATA_WIDTH: sensing-matrix RAM data, 1-cycle read latency.
REQ-012 Port res_read_addr, output, 8: residual RAM read address.
REQ-013 Port res_read_data, input, DATA_WIDTH: residual RAM data, 1-cycle read latency.
REQ-014 Port res_write_enable, output, 1: residual RAM write strobe.
REQ-015 Port res_write_addr, output, 8: residual RAM write address.
REQ-016 Port res_write_data, output, DATA_WIDTH: updated residual word.
REQ-017 Port busy, output, 1: pass in progress.
REQ-018 Port done, output, 1: one-cycle pulse, pass complete.
REQ-019 Port error, output, 1: one-cycle pulse, start rejected for an illegal column.
REQ-020 Port residual_energy, output, DATA_WIDTH: sum of squares of the updated residual; valid from done onward.

Function
REQ-021 The block SHALL compute r[i] <= r[i] - coefficient*phi[column*ROWS+i] for i = 0..ROWS-1 in place.
REQ-022 States are IDLE, RUN and FINISH; the block SHALL reset to IDLE.
REQ-023 In IDLE, start=1 with column < COLUMNS SHALL latch column and coefficient, clear the row counter and the energy accumulator, and move to RUN.
REQ-024 In IDLE, start=1 with column >= COLUMNS SHALL leave the state at IDLE and pulse error high for exactly one cycle.
REQ-025 start SHALL be ignored in RUN and FINISH.
REQ-026 In RUN, with the row counter k < ROWS, the block SHALL drive phi_read_addr = column*ROWS + k and res_read_addr = k, then increment k.
REQ-027 In the cycle after the read of row k was issued, res_write_enable SHALL be 1, res_write_addr SHALL be k, and res_write_data SHALL be the updated value of row k.
REQ-028 The read of row k+1 and the write of row k SHALL overlap, giving one row per cycle.
REQ-029 res_write_enable SHALL be 0 in all other cycles.
REQ-030 Product: full 2*DATA_WIDTH signed product, arithmetic right shift by FRAC_BITS, truncated to DATA_WIDTH.
REQ-031 Subtraction SHALL wrap modulo 2^DATA_WIDTH, with no saturation.
REQ-032 The energy accumulator SHALL add (new_r*new_r)>>>FRAC_BITS for each written row and SHALL saturate at the maximum positive DATA_WIDTH value.
REQ-033 Latency: with start sampled at edge E0, the writes SHALL commit at edges E2 through E(ROWS+1).
REQ-034 The state SHALL move to FINISH at edge E(ROWS+1).
REQ-035 done SHALL be high for exactly the one cycle spent in FINISH, and the state SHALL then return to IDLE.
REQ-036 busy SHALL be 1 in RUN and FINISH and 0 in IDLE.
REQ-037 A new start SHALL be accepted in the cycle after done.
REQ-038 residual_energy SHALL hold its value until the next accepted start.
REQ-039 coefficient = 0 SHALL still perform all ROWS writes, with the residual unchanged.

Reset
REQ-040 reset_n=0 at a rising edge SHALL force the state to IDLE, clear the row counter, and set busy, done, error, res_write_enable and residual_energy to 0.
REQ-041 When reset is applied mid-pass, res_write_enable SHALL be 0 from that edge onward, and the rows already written SHALL stay modified.
REQ-042 phi_read_addr, res_read_addr and res_write_addr SHALL be 0 in IDLE.

Verification
REQ-043 Residual {-1,-2,-2,1}, column 0 = {1,1,1,1}, coefficient -1 -> residual {0,-1,-1,2}, energy 6, done at E(ROWS+1)+1, exactly 4 writes.
REQ-044 Same initial residual, column 1 = {1,1,-1,-1}, coefficient 2 -> residual {-3,-4,0,3}, energy 34.
REQ-045 start with column 8 -> error pulses for 1 cycle, no writes, busy stays 0.
REQ-046 start re-asserted while busy, with different column and coefficient -> ignored, and the result matches the first request.
REQ-047 reset_n low after the second write -> rows 0 and 1 updated, rows 2 and 3 untouched, all outputs 0, and a following start completes normally.
REQ-048 Residual word 32'h7FFFFFFF with product -1 -> written value 32'h80000000 (wrap), and energy saturates at 32'h7FFFFFFF.
